// File: rtl/ay_bus_ctrl.sv
// AY-style PSG bus interface: 16 width-masked registers, latch/write/read bus modes, clk_en prescaler.
// Register updates appear on outputs one clk after commit; reads are combinational and there is no backpressure.
module ay_bus_ctrl #(
  parameter logic [3:0] CHIP_ADDR = 4'h0,
  parameter int         CLK_DIV   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        bdir,
  input  logic        bc1,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic [11:0] period_a,
  output logic [11:0] period_b,
  output logic [11:0] period_c,
  output logic [4:0]  noise_period,
  output logic [7:0]  mixer,
  output logic [4:0]  amp_a,
  output logic [4:0]  amp_b,
  output logic [4:0]  amp_c,
  output logic [15:0] env_period,
  output logic [3:0]  env_shape,
  output logic        env_restart,
  output logic        tick
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;
  localparam logic [1:0] MODE_LATCH = 2'b11;

  typedef enum logic {WR_IDLE, WR_ACTIVE} wr_state_t;

  logic [7:0]    regs [16];
  logic [3:0]    addr;
  logic          selected;
  logic [CW-1:0] presc;
  logic [1:0]    mode;
  logic          wr_commit;
  wr_state_t     wr_state, wr_state_nxt;

  function automatic logic [7:0] reg_mask(input logic [3:0] a);
    case (a)
      4'd1, 4'd3, 4'd5, 4'd13: reg_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: reg_mask = 8'h1F;
      default:                 reg_mask = 8'hFF;
    endcase
  endfunction

  assign mode = {bdir, bc1};

  // Only the first cycle of a write phase commits; the FSM remembers we are already inside one.
  always_ff @(posedge clk) begin
    if (!reset) wr_state <= WR_IDLE;
    else        wr_state <= wr_state_nxt;
  end

  always_comb begin
    wr_state_nxt = wr_state;
    wr_commit    = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (mode == MODE_WRITE) begin
          wr_state_nxt = WR_ACTIVE;
          wr_commit    = selected;
        end
      end
      WR_ACTIVE: begin
        if (mode != MODE_WRITE) wr_state_nxt = WR_IDLE;
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
      addr        <= 4'h0;
      selected    <= 1'b0;
      env_restart <= 1'b0;
    end else begin
      env_restart <= wr_commit && (addr == 4'd13);
      if (wr_commit) regs[addr] <= data_in & reg_mask(addr);
      if (mode == MODE_LATCH) begin
        addr     <= data_in[3:0];
        selected <= (data_in[7:4] == CHIP_ADDR);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)      presc <= '0;
    else if (clk_en) presc <= (presc == LAST) ? '0 : presc + 1'b1;
  end

  assign tick     = reset && clk_en && (presc == LAST);
  assign data_oe  = reset && (mode == MODE_READ) && selected;
  assign data_out = data_oe ? regs[addr] : 8'h00;

  assign period_a     = {regs[1][3:0], regs[0]};
  assign period_b     = {regs[3][3:0], regs[2]};
  assign period_c     = {regs[5][3:0], regs[4]};
  assign noise_period = regs[6][4:0];
  assign mixer        = regs[7];
  assign amp_a        = regs[8][4:0];
  assign amp_b        = regs[9][4:0];
  assign amp_c        = regs[10][4:0];
  assign env_period   = {regs[12], regs[11]};
  assign env_shape    = regs[13][3:0];

endmodule

// File: tb/tb_ay_bus_ctrl.sv
// Scoreboard bench for ay_bus_ctrl: directed scenarios then random bus traffic against a register-file model.
module tb_ay_bus_ctrl;

  localparam logic [3:0] CHIP = 4'h0;
  localparam int         DIV  = 8;

  logic        clk = 1'b0;
  logic        reset, clk_en, bdir, bc1;
  logic [7:0]  data_in, data_out;
  logic        data_oe, env_restart, tick;
  logic [11:0] period_a, period_b, period_c;
  logic [4:0]  noise_period, amp_a, amp_b, amp_c;
  logic [7:0]  mixer;
  logic [15:0] env_period;
  logic [3:0]  env_shape;

  always #5 clk = ~clk;

  ay_bus_ctrl #(.CHIP_ADDR(CHIP), .CLK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .bdir(bdir), .bc1(bc1),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .period_a(period_a), .period_b(period_b), .period_c(period_c),
    .noise_period(noise_period), .mixer(mixer),
    .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c),
    .env_period(env_period), .env_shape(env_shape),
    .env_restart(env_restart), .tick(tick)
  );

  typedef struct {
    logic        oe;
    logic [7:0]  dout;
    logic        tk;
    logic        rs;
    logic [7:0]  r [16];
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_regs [16];
  logic [3:0] m_addr;
  logic       m_sel;
  logic       m_in_write;
  logic       m_restart;
  int         m_en_count;

  function automatic logic [7:0] width_mask(input int idx);
    if (idx == 1 || idx == 3 || idx == 5 || idx == 13) return 8'h0F;
    if (idx == 6 || idx == 8 || idx == 9 || idx == 10) return 8'h1F;
    return 8'hFF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_addr = 4'h0; m_sel = 1'b0; m_in_write = 1'b0; m_restart = 1'b0; m_en_count = 0;
  endtask

  // One bus cycle: drive inputs, push this cycle's expected outputs, advance the model past the next edge.
  task automatic step(input logic [1:0] mode, input logic [7:0] d, input logic en, input logic rst);
    exp_t e;
    @(posedge clk); #1;
    {bdir, bc1} = mode; data_in = d; clk_en = en; reset = rst;
    e.oe   = rst && (mode == 2'b01) && m_sel;
    e.dout = e.oe ? m_regs[m_addr] : 8'h00;
    e.tk   = rst && en && ((m_en_count % DIV) == DIV - 1);
    e.rs   = m_restart;
    for (int i = 0; i < 16; i++) e.r[i] = m_regs[i];
    q.push_back(e);
    if (!rst) begin
      model_reset();
    end else begin
      m_restart = 1'b0;
      if (mode == 2'b10 && !m_in_write && m_sel) begin
        m_regs[m_addr] = d & width_mask(int'(m_addr));
        m_restart = (m_addr == 4'd13);
      end
      m_in_write = (mode == 2'b10);
      if (mode == 2'b11) begin
        m_addr = d[3:0];
        m_sel  = (d[7:4] == CHIP);
      end
      if (en) m_en_count = (m_en_count + 1) % DIV;
    end
  endtask

  task automatic bus(input logic [1:0] mode, input logic [7:0] d);
    step(mode, d, 1'b1, 1'b1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("data_oe", 32'(data_oe), 32'(e.oe));
      chk("data_out", 32'(data_out), 32'(e.dout));
      chk("tick", 32'(tick), 32'(e.tk));
      chk("env_restart", 32'(env_restart), 32'(e.rs));
      chk("period_a", 32'(period_a), 32'({e.r[1][3:0], e.r[0]}));
      chk("period_b", 32'(period_b), 32'({e.r[3][3:0], e.r[2]}));
      chk("period_c", 32'(period_c), 32'({e.r[5][3:0], e.r[4]}));
      chk("noise_period", 32'(noise_period), 32'(e.r[6][4:0]));
      chk("mixer", 32'(mixer), 32'(e.r[7]));
      chk("amps", 32'({amp_a, amp_b, amp_c}), 32'({e.r[8][4:0], e.r[9][4:0], e.r[10][4:0]}));
      chk("env_period", 32'(env_period), 32'({e.r[12], e.r[11]}));
      chk("env_shape", 32'(env_shape), 32'(e.r[13][3:0]));
    end
  end

  initial begin
    int pulses;
    int ticks;
    logic [1:0] md;
    logic [7:0] dv;

    reset = 1'b0; clk_en = 1'b0; bdir = 1'b0; bc1 = 1'b0; data_in = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    step(2'b00, 8'h00, 1'b1, 1'b0);
    step(2'b00, 8'h00, 1'b1, 1'b0);
    #2;
    chk("reset_period_a", 32'(period_a), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);

    // Two-register period write and masked readback
    bus(2'b11, 8'h01); bus(2'b10, 8'hFF); bus(2'b11, 8'h00); bus(2'b10, 8'h34); bus(2'b00, 8'h00);
    #2; chk("dir_period_a", 32'(period_a), 32'hF34);
    bus(2'b11, 8'h01); bus(2'b01, 8'h00);
    #2; chk("dir_read_r1", 32'({data_oe, data_out}), 32'h10F);

    // Long write phase gives one envelope restart; a repeat write gives another
    bus(2'b11, 8'h0D);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin bus(2'b10, 8'h0A); #2; pulses += int'(env_restart); end
    bus(2'b00, 8'h00); #2; pulses += int'(env_restart);
    bus(2'b00, 8'h00); #2; pulses += int'(env_restart);
    chk("dir_restart_once", 32'(pulses), 32'd1);
    chk("dir_env_shape", 32'(env_shape), 32'hA);
    bus(2'b10, 8'h0A); bus(2'b00, 8'h00);
    #2; chk("dir_restart_again", 32'(env_restart), 32'h1);

    // Foreign chip select is ignored
    bus(2'b11, 8'h17); bus(2'b10, 8'h55); bus(2'b00, 8'h00); bus(2'b01, 8'h00);
    #2; chk("dir_foreign_oe", 32'(data_oe), 32'h0);
    chk("dir_foreign_mixer", 32'(mixer), 32'h0);
    bus(2'b11, 8'h07); bus(2'b10, 8'h55); bus(2'b00, 8'h00);
    #2; chk("dir_mixer", 32'(mixer), 32'h55);

    // Prescaler: any 16 enabled cycles hold exactly two ticks
    ticks = 0;
    for (int i = 0; i < 16; i++) begin bus(2'b00, 8'h00); #2; ticks += int'(tick); end
    chk("dir_ticks_en", 32'(ticks), 32'd2);
    ticks = 0;
    for (int i = 0; i < 32; i++) begin
      step(2'b00, 8'h00, 1'(i % 2 == 0), 1'b1); #2;
      ticks += int'(tick);
      if (i % 2 == 1) chk("dir_tick_when_off", 32'(tick), 32'h0);
    end
    chk("dir_ticks_toggle", 32'(ticks), 32'd2);

    // Amplitude mask, then reset in the middle of a write phase
    bus(2'b11, 8'h08); bus(2'b10, 8'hFF); bus(2'b00, 8'h00);
    #2; chk("dir_amp_a", 32'(amp_a), 32'h1F);
    bus(2'b01, 8'h00);
    #2; chk("dir_read_r8", 32'(data_out), 32'h1F);
    bus(2'b11, 8'h02); bus(2'b10, 8'h77);
    step(2'b10, 8'h77, 1'b1, 1'b0); step(2'b10, 8'h77, 1'b1, 1'b0);
    step(2'b10, 8'h77, 1'b1, 1'b1); step(2'b10, 8'h77, 1'b1, 1'b1); bus(2'b00, 8'h00);
    #2; chk("dir_post_reset", 32'({period_b, amp_a, mixer}), 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      md = 2'($urandom_range(0, 3));
      dv = 8'($urandom);
      if (md == 2'b11 && $urandom_range(0, 9) < 8) dv[7:4] = CHIP;
      step(md, dv, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) != 0));
    end
    bus(2'b00, 8'h00);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
